// File: rtl/spi_target_regbank.sv
// SPI target with a byte-wide register bank.
// Oversamples sclk/cs_n/mosi in the clk domain, handles SPI modes 0-3,
// single and auto-incrementing burst transfers, and reports completed
// writes and aborted frames to local logic.
module spi_target_regbank #(
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] MODE,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_abort
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;

    logic [1:0] state;
    logic [1:0] mode_q;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic       rw_q;
    logic [6:0] ptr;
    logic [7:0] tx;
    logic [7:0] regs [NUM_REGS];

    logic       sclk_toggle;
    logic       lead_edge;
    logic       trail_edge;
    logic       sample_edge;
    logic       shift_edge;
    logic       cs_fall;
    logic       cs_rise;
    logic [7:0] byte_in;
    logic       byte_done;
    logic [6:0] ptr_next;
    logic       write_fire;
    logic [7:0] cmd_word;
    logic [7:0] next_word;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchronise the asynchronous SPI inputs and keep one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= {SYNC_STAGES{MODE[1]}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= MODE[1];
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // Classify sclk transitions against the mode latched at frame start
    always_comb begin
        sclk_toggle = sclk_s ^ sclk_prev;
        lead_edge   = sclk_toggle && (sclk_prev == mode_q[1]);
        trail_edge  = sclk_toggle && (sclk_s == mode_q[1]);
        sample_edge = mode_q[0] ? trail_edge : lead_edge;
        shift_edge  = mode_q[0] ? lead_edge : trail_edge;
        cs_fall     = cs_prev & ~cs_s;
        cs_rise     = ~cs_prev & cs_s;
        byte_in     = {shift_in, mosi_s};
        byte_done   = sample_edge && (bit_cnt == 3'd7);
        ptr_next    = ptr + 7'd1;
        write_fire  = (state == DATA) && !cs_rise && byte_done && !rw_q;
    end

    // Register read muxes: local port, first read byte, and next burst byte (0x00 when out of range)
    always_comb begin
        rd_data   = '0;
        cmd_word  = '0;
        next_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i))
                rd_data = regs[i];
            if (byte_in[6:0] == 7'(i))
                cmd_word = regs[i];
            if (ptr_next == 7'(i))
                next_word = regs[i];
        end
    end

    // Frame state machine, shift registers, miso drive and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= MODE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            rw_q        <= 1'b0;
            ptr         <= '0;
            tx          <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_abort <= 1'b0;
        end else begin
            wr_strobe   <= 1'b0;
            frame_abort <= 1'b0;
            if (cs_rise) begin
                // a deselect that lands mid-byte drops the partial byte
                if (state != IDLE && bit_cnt != 3'd0)
                    frame_abort <= 1'b1;
                state   <= IDLE;
                bit_cnt <= '0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            mode_q  <= MODE;
                            bit_cnt <= '0;
                            miso_oe <= 1'b1;
                            miso    <= 1'b0;
                            tx      <= '0;
                        end
                    end
                    CMD: begin
                        if (sample_edge) begin
                            shift_in <= byte_in[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw_q  <= byte_in[7];
                                ptr   <= byte_in[6:0];
                                state <= DATA;
                                if (byte_in[7])
                                    tx <= cmd_word;
                            end
                        end
                    end
                    DATA: begin
                        if (sample_edge) begin
                            shift_in <= byte_in[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr <= ptr_next;
                                if (rw_q) begin
                                    tx <= next_word;
                                end else if ({1'b0, ptr} < NUM_REGS_W) begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= byte_in;
                                end
                            end
                        end
                        if (shift_edge && rw_q) begin
                            miso <= tx[7];
                            tx   <= {tx[6:0], 1'b0};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Register bank: SPI writes land in the same cycle wr_strobe goes high
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (write_fire) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                if (ptr == 7'(i))
                    regs[i] <= byte_in;
        end
    end

endmodule

// File: tb/tb_spi_target_regbank.sv
// Bench for spi_target_regbank: bit-banged SPI master at clk/8 in all modes,
// directed scenarios plus random frames checked against a register-array model.
module tb_spi_target_regbank;

    localparam int NUM_REGS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] MODE;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_abort;

    spi_target_regbank #(
        .NUM_REGS   (NUM_REGS),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MODE       (MODE),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_abort(frame_abort)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    int         checks    = 0;
    int         errors    = 0;
    int         abort_cnt = 0;
    logic [14:0] strobe_q [$];
    logic [14:0] exp_q [$];
    logic [7:0] model [NUM_REGS];
    logic [7:0] fb [8];
    logic [7:0] prev_rd          = '0;
    logic [7:0] rd_at_strobe     = '0;
    logic [7:0] rd_before_strobe = '0;

    // Collect write strobes and abort pulses, and rd_data around each strobe
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_strobe) begin
                strobe_q.push_back({wr_addr, wr_data});
                rd_at_strobe     = rd_data;
                rd_before_strobe = prev_rd;
            end
            if (frame_abort)
                abort_cnt++;
        end
        prev_rd = rd_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rd(input logic [6:0] a);
        logic [7:0] e;
        e = 8'h00;
        if (int'(a) < NUM_REGS)
            e = model[a];
        rd_addr = a;
        #1;
        check("rd_data", rd_data, e);
    endtask

    // Shift nb bits of d (MSB first) and capture miso at each sample instant
    task automatic send_bits(input logic [1:0] m, input logic [7:0] d, input int nb,
                             output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            if (!m[0]) begin
                mosi = d[7-i];
                clks(4);
                rx = {rx[6:0], miso};
                check("oe_in_frame", miso_oe, 1);
                sclk = ~m[1];
                clks(4);
                sclk = m[1];
            end else begin
                sclk = ~m[1];
                mosi = d[7-i];
                clks(4);
                rx = {rx[6:0], miso};
                check("oe_in_frame", miso_oe, 1);
                sclk = m[1];
                clks(4);
            end
        end
    endtask

    task automatic start_frame(input logic [1:0] m);
        MODE = m;
        sclk = m[1];
        mosi = 1'b0;
        clks(8);
        check("oe_idle", miso_oe, 0);
        cs_n = 1'b0;
        clks(4);
    endtask

    task automatic end_frame();
        clks(4);
        cs_n = 1'b1;
        clks(8);
        check("oe_after", miso_oe, 0);
        check("miso_after", miso, 0);
    endtask

    // Run fb[0..nbytes-1] as a frame, optionally followed by a partial byte of tail bits
    task automatic do_frame(input logic [1:0] m, input int nbytes, input int tail);
        logic       rw;
        logic [6:0] a0;
        int         a;
        int         ab0;
        logic [7:0] r;
        logic [7:0] e;
        rw = fb[0][7];
        a0 = fb[0][6:0];
        strobe_q.delete();
        exp_q.delete();
        ab0 = abort_cnt;
        start_frame(m);
        MODE = 2'($urandom);
        for (int k = 0; k < nbytes; k++) begin
            send_bits(m, fb[k], 8, r);
            if (k == 0) begin
                check("cmd_miso", r, 0);
            end else begin
                a = (int'(a0) + k - 1) % 128;
                if (rw) begin
                    e = 8'h00;
                    if (a < NUM_REGS)
                        e = model[a];
                    check("rd_byte", r, e);
                end else begin
                    check("wr_miso", r, 0);
                    if (a < NUM_REGS) begin
                        model[a] = fb[k];
                        exp_q.push_back({7'(a), fb[k]});
                    end
                end
            end
        end
        if (tail > 0)
            send_bits(m, fb[nbytes], tail, r);
        end_frame();
        check("strobe_cnt", strobe_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++)
            check("strobe_addr_data", strobe_q[i], exp_q[i]);
        check("abort_cnt", abort_cnt - ab0, (tail > 0) ? 1 : 0);
    endtask

    initial begin
        logic [7:0] r;
        logic [1:0] m;
        int         nb;
        int         tail;
        int         ab0;
        logic [6:0] a;

        reset   = 1'b1;
        MODE    = 2'd0;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        rd_addr = 7'd0;
        for (int i = 0; i < NUM_REGS; i++)
            model[i] = 8'h00;
        clks(3);
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_abort", frame_abort, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        clks(4);

        // mode 0 single write, with rd_data timing around the strobe
        rd_addr = 7'd3;
        fb[0] = 8'h03; fb[1] = 8'hA5;
        do_frame(2'd0, 2, 0);
        check("rd_old_at_strobe", rd_before_strobe, 8'h00);
        check("rd_new_at_strobe", rd_at_strobe, 8'hA5);
        check_rd(7'd3);

        // mode 3 read back
        fb[0] = 8'h83; fb[1] = 8'h00;
        do_frame(2'd3, 2, 0);

        // mode 1 burst write running past the end of the bank, mode 2 burst read
        fb[0] = 8'h06; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33;
        do_frame(2'd1, 4, 0);
        fb[0] = 8'h86; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
        do_frame(2'd2, 4, 0);

        // mode 0 abort after 5 data bits, then a clean write
        fb[0] = 8'h01; fb[1] = 8'hC3;
        do_frame(2'd0, 1, 5);
        check_rd(7'd1);
        fb[0] = 8'h01; fb[1] = 8'h5A;
        do_frame(2'd0, 2, 0);
        check_rd(7'd1);

        // write then read in every mode
        for (int i = 0; i < 4; i++) begin
            fb[0] = {1'b0, 7'(i)}; fb[1] = 8'($urandom);
            do_frame(2'(i), 2, 0);
            fb[0] = {1'b1, 7'(i)}; fb[1] = 8'h00;
            do_frame(2'(i), 2, 0);
        end

        // random frames, including wrap-around and partial trailing bytes
        for (int n = 0; n < 40; n++) begin
            m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 3)
                a = 7'($urandom_range(125, 127));
            else
                a = 7'($urandom_range(0, NUM_REGS + 1));
            fb[0] = {1'($urandom_range(0, 1)), a};
            nb = $urandom_range(2, 6);
            for (int k = 1; k < 8; k++)
                fb[k] = 8'($urandom);
            tail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            do_frame(m, nb, tail);
        end

        for (int i = 0; i < NUM_REGS + 2; i++)
            check_rd(7'(i));
        check_rd(7'd127);

        // reset in the middle of a read frame
        rd_addr = 7'd3;
        ab0 = abort_cnt;
        start_frame(2'd2);
        send_bits(2'd2, 8'h83, 8, r);
        send_bits(2'd2, 8'h00, 3, r);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_miso", miso, 0);
        check("rst_mid_oe", miso_oe, 0);
        check("rst_mid_strobe", wr_strobe, 0);
        check("rst_mid_wr_addr", wr_addr, 0);
        check("rst_mid_wr_data", wr_data, 0);
        check("rst_mid_rd3", rd_data, 0);
        cs_n = 1'b1;
        sclk = MODE[1];
        clks(3);
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            model[i] = 8'h00;
        clks(6);
        check("rst_mid_no_abort", abort_cnt - ab0, 0);
        fb[0] = 8'h83; fb[1] = 8'h00;
        do_frame(2'd1, 2, 0);
        for (int i = 0; i < NUM_REGS; i++)
            check_rd(7'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
